fb_rect_fill_ctrl: RTL
======================

Name: fb_rect_fill_ctrl

Overview:
- Sequences rectangle-fill commands into the write port (addr_in/data_in/regwrite) of the 128x96, 3-bit-per-pixel dual-port framebuffer. The VGA driver reads the same framebuffer.
- Game logic issues one command per object (background clear, paddles, ball). The block expands each command into one pixel write per cycle, clipped to the screen.
- A window input restricts writes to allowed periods, e.g. vertical blanking.

Parameters:
- SCREEN_X, 128, framebuffer width in pixels
- SCREEN_Y, 96, framebuffer height in pixels
- AW, 14, framebuffer address width
- DW, 3, pixel width (R,G,B, 1 bit each)

Ports:
- clk  in  1  pixel clock (25 MHz domain, same as framebuffer)
- rst  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_x0  in  7  left column
- cmd_y0  in  7  top row
- cmd_w  in  8  width in pixels, 0..255
- cmd_h  in  7  height in pixels, 0..127
- cmd_color  in  DW  fill colour
- wr_win  in  1  write window; 1 = writes permitted this cycle
- mem_px_addr  out  AW  framebuffer write address
- mem_px_data  out  DW  framebuffer write data
- px_wr  out  1  framebuffer write strobe
- busy  out  1  command in progress
- done  out  1  one-cycle pulse at command completion
- err  out  1  one-cycle pulse with done when the command origin is off-screen

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - state to IDLE
  - cmd_ready=1
  - px_wr=0, mem_px_addr=0, mem_px_data=0
  - busy=0, done=0, err=0
  - all internal counters to 0
- Reset mid-fill aborts the command. Pixels already written stay in RAM. No done pulse is issued.
- All outputs are registered.
- Handshake:
  - A command is accepted on a rising edge with cmd_valid=1 and cmd_ready=1.
  - cmd_ready=1 only in IDLE. cmd_* are sampled into registers at acceptance. cmd_valid while busy is ignored, and the requester holds it.
- States:
  - IDLE: cmd_ready=1. On accept, go to SETUP.
  - SETUP (1 cycle): busy=1. Compute the clipped extents:
    - xe = min(x0+w, SCREEN_X) - 1
    - ye = min(y0+h, SCREEN_Y) - 1
    - Use 9-bit intermediate arithmetic; no wrap-around is permitted.
    - If x0>=SCREEN_X or y0>=SCREEN_Y, go to DONE with err flagged.
    - Else if w==0 or h==0, go to DONE without error.
    - Else set x=x0, y=y0 and go to FILL.
  - FILL: on each cycle with wr_win=1, register:
    - px_wr=1
    - mem_px_addr = y*SCREEN_X + x (truncated to AW)
    - mem_px_data = colour
  - FILL advance rule:
    - If x<xe, then x++.
    - Otherwise x=x0; if y<ye, then y++; otherwise go to DONE.
  - FILL stall rule: with wr_win=0, px_wr=0 and x, y hold. The stall lasts indefinitely.
  - DONE (1 cycle): done=1; err=1 if flagged; busy=0 next cycle. Then go to IDLE.
- Ordering and latency:
  - Writes are row-major, top-left first.
  - Accept at edge T; first px_wr=1 at T+2 if wr_win is high.
  - For an unstalled command of N clipped pixels, done is asserted N+2 cycles after accept.
  - The next accept is possible the cycle after done.
- px_wr is never asserted outside FILL. No address >= SCREEN_X*SCREEN_Y is ever written.
- wr_win falling on the last pixel: that pixel is not written and FILL remains until a cycle with wr_win=1 writes it.

Decomposition:
- Package fb_pkg holds:
  - SCREEN_X, SCREEN_Y, AW, DW
  - colour constants BLACK=3'b000, RED=3'b100, GREEN=3'b010, BLUE=3'b001, WHITE=3'b111
  - state encoding IDLE/SETUP/FILL/DONE
- One sub-module: fb_addr_gen, the combinational y*SCREEN_X+x address computation. It reduces to concatenation when SCREEN_X is a power of two.
- Everything else stays in a single module.

Test Plan:
- Reset: hold rst=0 while cmd_valid=1 → cmd_ready=1, px_wr=0, busy=0, no accept. After release, one IDLE cycle precedes any write.
- Basic fill: x0=10, y0=5, w=3, h=2, color=3'b100, wr_win=1 → exactly 6 writes on consecutive cycles at addresses 650,651,652,778,779,780, data 3'b100. done asserted 8 cycles after accept; err=0.
- Clipping: x0=126, y0=95, w=5, h=4 → exactly 2 writes at 12286 and 12287. done without err.
- Degenerate and error cases:
  - w=0, h=7 → no writes; done 2 cycles after accept; err=0.
  - x0=127, y0=100 → no writes; done with err=1.
- Window stall: full clear (0,0,128,96,000) with wr_win toggling 1,0,0,1,... → 12288 writes total, none while wr_win=0. Address sequence contiguous 0..12287, no repeats.
- Mid-fill reset and back-to-back:
  - Assert rst=0 after 20 writes → outputs reset immediately, no done. A new command is then accepted normally.
  - Hold cmd_valid high across two commands → second accept occurs the cycle after the first done.

Source files
------------

// File: rtl/fb_pkg.sv
// fb_pkg: framebuffer geometry, pixel width, colour constants and fill-controller state encoding
package fb_pkg;
  localparam int SCREEN_X = 128;
  localparam int SCREEN_Y = 96;
  localparam int AW = 14;
  localparam int DW = 3;
  localparam int XW = 7;
  localparam int YW = 7;
  localparam logic [DW-1:0] BLACK = 3'b000;
  localparam logic [DW-1:0] RED   = 3'b100;
  localparam logic [DW-1:0] GREEN = 3'b010;
  localparam logic [DW-1:0] BLUE  = 3'b001;
  localparam logic [DW-1:0] WHITE = 3'b111;
  typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;
endpackage

// File: rtl/fb_addr_gen.sv
// fb_addr_gen: combinational y*SCREEN_X+x framebuffer address (x,y in; addr out), a concatenation when SCREEN_X is a power of two
module fb_addr_gen import fb_pkg::*; (
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  output logic [AW-1:0] addr
);
  localparam int XB = $clog2(SCREEN_X);
  if (SCREEN_X == (1 << XB) && XB == XW) begin : g_pow2
    assign addr = AW'({y, x});
  end else begin : g_mul
    assign addr = AW'(y * AW'(SCREEN_X)) + AW'(x);
  end
endmodule

// File: rtl/fb_rect_fill_ctrl.sv
// fb_rect_fill_ctrl: expands clipped rectangle-fill commands (cmd_* valid/ready) into one framebuffer write per wr_win cycle (mem_px_addr/mem_px_data/px_wr) with busy/done/err status
module fb_rect_fill_ctrl import fb_pkg::*; (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [6:0]    cmd_x0,
  input  logic [6:0]    cmd_y0,
  input  logic [7:0]    cmd_w,
  input  logic [6:0]    cmd_h,
  input  logic [DW-1:0] cmd_color,
  input  logic          wr_win,
  output logic [AW-1:0] mem_px_addr,
  output logic [DW-1:0] mem_px_data,
  output logic          px_wr,
  output logic          busy,
  output logic          done,
  output logic          err
);
  state_t state_q, state_d;
  logic [XW-1:0] x0_q, x0_d, x_q, x_d, xe_q, xe_d;
  logic [YW-1:0] y0_q, y0_d, y_q, y_d, ye_q, ye_d;
  logic [7:0] w_q, w_d;
  logic [6:0] h_q, h_d;
  logic [DW-1:0] color_q, color_d, data_q, data_d;
  logic [AW-1:0] addr_q, addr_d, addr_w;
  logic err_flag_q, err_flag_d, cmd_ready_q, cmd_ready_d, busy_q, busy_d;
  logic done_q, done_d, err_q, err_d, px_wr_q, px_wr_d;
  logic [8:0] sum_x, sum_y;
  logic off_screen;
  fb_addr_gen u_addr (.x(x_q), .y(y_q), .addr(addr_w));
  always_comb begin
    state_d = state_q;
    x0_d = x0_q;
    y0_d = y0_q;
    w_d = w_q;
    h_d = h_q;
    color_d = color_q;
    xe_d = xe_q;
    ye_d = ye_q;
    x_d = x_q;
    y_d = y_q;
    err_flag_d = err_flag_q;
    addr_d = addr_q;
    data_d = data_q;
    px_wr_d = 1'b0;
    done_d = 1'b0;
    err_d = 1'b0;
    sum_x = {2'b0, x0_q} + {1'b0, w_q};
    sum_y = {2'b0, y0_q} + {2'b0, h_q};
    off_screen = {2'b0, x0_q} >= 9'(SCREEN_X) || {2'b0, y0_q} >= 9'(SCREEN_Y);
    case (state_q)
      IDLE: if (cmd_valid) begin
        x0_d = cmd_x0;
        y0_d = cmd_y0;
        w_d = cmd_w;
        h_d = cmd_h;
        color_d = cmd_color;
        err_flag_d = 1'b0;
        state_d = SETUP;
      end
      SETUP: begin
        xe_d = XW'((sum_x > 9'(SCREEN_X) ? 9'(SCREEN_X) : sum_x) - 9'd1);
        ye_d = YW'((sum_y > 9'(SCREEN_Y) ? 9'(SCREEN_Y) : sum_y) - 9'd1);
        x_d = x0_q;
        y_d = y0_q;
        err_flag_d = off_screen;
        state_d = (off_screen || w_q == 8'd0 || h_q == 7'd0) ? DONE : FILL;
      end
      FILL: if (wr_win) begin
        px_wr_d = 1'b1;
        addr_d = addr_w;
        data_d = color_q;
        x_d = x_q < xe_q ? x_q + 7'd1 : x0_q;
        y_d = (x_q >= xe_q && y_q < ye_q) ? y_q + 7'd1 : y_q;
        state_d = (x_q >= xe_q && y_q >= ye_q) ? DONE : FILL;
      end
      default: begin
        done_d = 1'b1;
        err_d = err_flag_q;
        state_d = IDLE;
      end
    endcase
    cmd_ready_d = state_d == IDLE;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      x0_q <= '0;
      y0_q <= '0;
      w_q <= '0;
      h_q <= '0;
      color_q <= '0;
      xe_q <= '0;
      ye_q <= '0;
      x_q <= '0;
      y_q <= '0;
      err_flag_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      px_wr_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x0_q <= x0_d;
      y0_q <= y0_d;
      w_q <= w_d;
      h_q <= h_d;
      color_q <= color_d;
      xe_q <= xe_d;
      ye_q <= ye_d;
      x_q <= x_d;
      y_q <= y_d;
      err_flag_q <= err_flag_d;
      addr_q <= addr_d;
      data_q <= data_d;
      px_wr_q <= px_wr_d;
      done_q <= done_d;
      err_q <= err_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q <= busy_d;
    end
  end
  assign cmd_ready = cmd_ready_q;
  assign mem_px_addr = addr_q;
  assign mem_px_data = data_q;
  assign px_wr = px_wr_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err = err_q;
endmodule
